// File: rtl/embertrail_fetch.sv
// Instruction fetch unit: issues one halfword request at a time into a small
// circular buffer and presents 1- or 2-halfword instructions to the control unit.
module embertrail_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        iClock,
  input  logic        iReset,
  output logic [15:0] oInstAddrBus,
  output logic        oInstReq,
  input  logic        iInstGnt,
  input  logic        iInstValid,
  input  logic [15:0] iInstData,
  output logic [31:0] oIR,
  output logic [15:0] oPC,
  output logic        oIRValid,
  input  logic        iIRTake,
  input  logic        iRedirect,
  input  logic [15:0] iRedirectAddr,
  output logic [2:0]  oBufCount
);

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  // Storage is sized for the largest DEPTH; only the first DEPTH slots are addressed.
  logic [15:0] r_buf [0:7];
  logic [2:0]  r_head;
  logic [2:0]  r_count;
  logic        r_outstanding;
  logic        r_discard;
  logic [15:0] r_fetch_addr;
  logic [15:0] r_pc;

  logic        w_push;
  logic        w_pop;
  logic        w_ir_valid;
  logic        w_req;
  logic [2:0]  w_pop_n;
  logic [2:0]  w_tail;
  logic [2:0]  w_next_idx;
  logic [3:0]  w_fill;
  logic [15:0] w_head;
  logic [15:0] w_next;

  function automatic logic [2:0] wrap_idx(input logic [3:0] v);
    logic [2:0] r;
    if (v >= DEPTH_L) r = 3'(v - DEPTH_L);
    else              r = 3'(v);
    return r;
  endfunction

  assign w_tail     = wrap_idx({1'b0, r_head} + {1'b0, r_count});
  assign w_next_idx = wrap_idx({1'b0, r_head} + 4'd1);
  assign w_head     = r_buf[r_head];
  assign w_next     = r_buf[w_next_idx];

  // A response is only real if we are waiting for one and it is not a stale one.
  assign w_push     = iInstValid & r_outstanding & ~r_discard;
  assign w_fill     = {1'b0, r_count} + {3'b000, w_push};
  assign w_req      = iReset & ~iRedirect & (~r_outstanding | iInstValid) & (w_fill < DEPTH_L);

  assign w_ir_valid = (r_count != 3'd0) & (~w_head[15] | (r_count >= 3'd2));
  assign w_pop      = iIRTake & w_ir_valid & ~iRedirect;
  assign w_pop_n    = {1'b0, w_pop & w_head[15], w_pop & ~w_head[15]};

  assign oInstReq     = w_req;
  assign oInstAddrBus = r_fetch_addr;
  assign oPC          = r_pc;
  assign oIRValid     = w_ir_valid;
  assign oBufCount    = r_count;

  always_comb begin
    oIR = 32'h0;
    if (r_count >= 3'd2)      oIR = {w_next, w_head};
    else if (r_count == 3'd1) oIR = {16'h0000, w_head};
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      r_count       <= 3'd0;
      r_head        <= 3'd0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      r_fetch_addr  <= RESET_PC;
      r_pc          <= RESET_PC;
    end else if (iRedirect) begin
      r_count       <= 3'd0;
      r_head        <= 3'd0;
      r_fetch_addr  <= iRedirectAddr;
      r_pc          <= iRedirectAddr;
      // An in-flight request must have its eventual response thrown away.
      r_outstanding <= r_outstanding & ~iInstValid;
      r_discard     <= r_outstanding & ~iInstValid;
    end else begin
      if (w_req && iInstGnt) begin
        r_fetch_addr  <= r_fetch_addr + 16'd1;
        r_outstanding <= 1'b1;
      end else if (iInstValid) begin
        r_outstanding <= 1'b0;
      end
      if (iInstValid && r_outstanding) r_discard <= 1'b0;
      r_count <= r_count - w_pop_n + {2'b00, w_push};
      r_head  <= wrap_idx({1'b0, r_head} + {1'b0, w_pop_n});
      r_pc    <= r_pc + {13'b0, w_pop_n};
    end
  end

  always_ff @(posedge iClock) begin
    if (w_push && iReset && !iRedirect) r_buf[w_tail] <= iInstData;
  end

endmodule

// File: doc/embertrail_fetch.md
EMBERTRAIL_FETCH -- requirements
Module: embertrail_fetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction buffer size in 16-bit halfwords (range 2..7).
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL set the fetch and head address after reset.
REQ-003 iClock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 iReset  in  1  SHALL be a synchronous, active-low reset.
REQ-005 oInstAddrBus  out  16  SHALL carry the halfword address of the pending instruction-memory request.
REQ-006 oInstReq  out  1  SHALL request a fetch.
REQ-007 iInstGnt  in  1  SHALL mean memory accepted the request this cycle.
REQ-008 iInstValid  in  1  SHALL mean iInstData holds the response.
REQ-009 iInstData  in  16  SHALL be the returned halfword.
REQ-010 oIR  out  32  SHALL be the instruction register to the control unit: head halfword in [15:0], next halfword in [31:16].
REQ-011 oPC  out  16  SHALL be the address of the head halfword.
REQ-012 oIRValid  out  1  SHALL mean oIR holds a complete instruction.
REQ-013 iIRTake  in  1  SHALL mean the control unit consumes oIR this cycle.
REQ-014 iRedirect  in  1  SHALL request a flush and refetch (branch taken).
REQ-015 iRedirectAddr  in  16  SHALL be the refetch target.
REQ-016 oBufCount  out  3  SHALL report the number of buffered halfwords.

Function
REQ-017 Instruction length SHALL be 2 halfwords when the head halfword has bit 15 set, else 1.
REQ-018 oIRValid SHALL be (count>=1) and (head[15]==0 or count>=2), decoded combinationally from registered state.
REQ-019 oIR[31:16] SHALL be 16'h0000 when count<2; oIR SHALL be 32'h0 when count==0.
REQ-020 Only one memory request SHALL be outstanding at a time; the outstanding flag sets on oInstReq&iInstGnt and clears on iInstValid.
REQ-021 oInstReq SHALL be (iReset==1) & ~iRedirect & (~outstanding | iInstValid) & (count + push < DEPTH), where push = iInstValid & outstanding & ~discard.
REQ-022 oInstAddrBus SHALL equal the fetch address; it and oInstReq SHALL hold stable until granted.
REQ-023 On grant, the fetch address SHALL increment by 1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-024 Responses SHALL arrive no earlier than the cycle after grant; iInstValid with outstanding==0 SHALL be ignored.
REQ-025 A response with discard==0 SHALL be written to the buffer tail; with discard==1 it SHALL be dropped and discard cleared.
REQ-026 iIRTake with oIRValid==1 SHALL pop the instruction length (1 or 2) and advance oPC by the same amount modulo 2^16; iIRTake with oIRValid==0 SHALL be ignored.
REQ-027 A push and a pop in the same cycle SHALL both take effect: count_next = count - pop + push, with order preserved.
REQ-028 iRedirect SHALL, at the rising edge, perform all of the following:
- set count to 0;
- load iRedirectAddr into both the fetch address and oPC;
- ignore iIRTake and drop any response in that cycle;
- set discard=1 if a request is outstanding with no response in that cycle.
REQ-029 While discard==1, no new request SHALL issue until the stale response arrives.
REQ-030 Priority SHALL be reset > redirect > normal push/pop/grant.

Reset
REQ-031 With iReset==0 at a rising edge, the block SHALL set count=0, outstanding=0, discard=0, fetch address=RESET_PC and oPC=RESET_PC.
REQ-032 During and after reset, until new activity: oInstReq=0 while iReset==0, oIRValid=0, oIR=32'h0, oBufCount=0, oPC=RESET_PC, oInstAddrBus=RESET_PC.
REQ-033 Reset asserted mid-transaction SHALL abandon any outstanding request without setting discard; the memory model SHALL be reset together with the block.

Verification
REQ-034 Reset: iReset=0 for 2 cycles -> oInstReq=0, oIRValid=0, oBufCount=0, oPC=16'h0000. Release -> oInstReq=1, oInstAddrBus=16'h0000.
REQ-035 Single halfword: addr 0 returns 16'h0001 -> oIRValid=1, oIR=32'h00000001, oPC=0. Pulse iIRTake -> oPC=1, oBufCount decrements.
REQ-036 Dual halfword: addr 0 returns 16'h8123 -> oIRValid=0. Then addr 1 returns 16'h4567 -> oIR=32'h45678123, oIRValid=1. Take -> oPC=2.
REQ-037 Full buffer: iIRTake=0, grant every cycle, 1-cycle latency -> oBufCount reaches 4, then oInstReq=0 with oInstAddrBus=16'h0004 held.
REQ-038 Redirect while outstanding: grant addr 2, assert iRedirect with 16'h0040 before the response -> stale response dropped, oBufCount=0, next request 16'h0040, oPC=16'h0040.
REQ-039 Wrap: redirect to 16'hFFFF; data 16'h8AAA at FFFF, 16'h5555 at 0000 -> oIR=32'h55558AAA, oPC=16'hFFFF. Take -> oPC=16'h0001.
